// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit frame controller (start, data, optional parity, stop)
//
// Sequences one UART frame per accepted word alongside an external serializer.
// The line is idle high. A frame is a start bit, DATA_WIDTH data bits sent
// LSB-first, an optional parity bit and a stop bit. The line output is
// registered, so it lags the state by exactly one cycle and cannot glitch.
//
// Optional build macro: UART_TX_TWO_STOP_EN
//   defined   : adds a STOP2 state after STOP, giving two stop bits
//   undefined : one stop bit; no STOP2 state is built
//
// Ports:
//   CLK        in   1           clock, rising edge
//   RST        in   1           asynchronous active-low reset
//   P_DATA     in   DATA_WIDTH  parallel word, used here for parity only
//   Data_Valid in   1           word offer; accepted when Busy=0 (IDLE)
//   PAR_EN     in   1           1 = append parity bit (sampled at accept)
//   PAR_TYP    in   1           0 = even, 1 = odd parity (sampled at accept)
//   ser_done   in   1           serializer: high during last data-bit cycle
//   ser_out    in   1           serializer: current data bit
//   ser_en     out  1           serializer shift/count enable (DATA state)
//   Busy       out  1           frame in progress (registered)
//   TX_OUT     out  1           serial line, idle high (registered)

module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_done,
    input  logic                  ser_out,
    output logic                  ser_en,
    output logic                  Busy,
    output logic                  TX_OUT
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
`ifdef UART_TX_TWO_STOP_EN
        ,
        S_STOP2  = 3'd5
`endif
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic   r_parity;
    logic   r_par_en;
    logic   r_busy;
    logic   r_tx;

    logic   w_line;
    logic   w_ser_en;
    logic   w_accept;

    // Busy is 0 in every IDLE cycle, so IDLE plus Data_Valid is exactly the
    // Data_Valid & !Busy condition the serializer uses to load P_DATA.
    assign w_accept = (r_state == S_IDLE) && Data_Valid;

    always_comb begin
        w_next_state = r_state;
        w_ser_en     = 1'b0;
        w_line       = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (Data_Valid) begin
                    w_next_state = S_START;
                end
            end
            S_START: begin
                w_line       = 1'b0;
                w_next_state = S_DATA;
            end
            S_DATA: begin
                w_ser_en = 1'b1;
                w_line   = ser_out;
                // ser_done is only meaningful here; elsewhere it is ignored.
                if (ser_done) begin
                    w_next_state = r_par_en ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                w_line       = r_parity;
                w_next_state = S_STOP;
            end
            S_STOP: begin
                w_line = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
                w_next_state = S_STOP2;
`else
                w_next_state = S_IDLE;
`endif
            end
`ifdef UART_TX_TWO_STOP_EN
            S_STOP2: begin
                w_line       = 1'b1;
                w_next_state = S_IDLE;
            end
`endif
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_tx     <= 1'b1;
            r_parity <= 1'b0;
            r_par_en <= 1'b0;
        end else begin
            r_state <= w_next_state;
            // Registered from next state so Busy rises the cycle after
            // accept and falls on entry to IDLE.
            r_busy  <= (w_next_state != S_IDLE);
            r_tx    <= w_line;
            // Frame options are frozen at accept; later input changes do
            // not disturb the frame in flight.
            if (w_accept) begin
                r_parity <= (^P_DATA) ^ PAR_TYP;
                r_par_en <= PAR_EN;
            end
        end
    end

    assign ser_en = w_ser_en;
    assign Busy   = r_busy;
    assign TX_OUT = r_tx;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - randomized scoreboard bench for uart_tx_ctrl with a serializer model

module tb_uart_tx_ctrl;

    localparam int W = 8;
`ifdef UART_TX_TWO_STOP_EN
    localparam int STOP_BITS = 2;
`else
    localparam int STOP_BITS = 1;
`endif

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [W-1:0] P_DATA = '0;
    logic         Data_Valid = 1'b0;
    logic         PAR_EN = 1'b0;
    logic         PAR_TYP = 1'b0;
    logic         ser_done;
    logic         ser_out;
    logic         ser_en;
    logic         Busy;
    logic         TX_OUT;

    int total = 0;
    int bad   = 0;

    uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .Data_Valid(Data_Valid),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .ser_done  (ser_done),
        .ser_out   (ser_out),
        .ser_en    (ser_en),
        .Busy      (Busy),
        .TX_OUT    (TX_OUT)
    );

    always #5 CLK = ~CLK;

    // Serializer stand-in: loads on Data_Valid & !Busy, shifts LSB-first on ser_en.
    logic [W-1:0] s_sh;
    int           s_cnt;
    logic         noise = 1'b0;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s_sh  <= '0;
            s_cnt <= W;
        end else if (Data_Valid && !Busy) begin
            s_sh  <= P_DATA;
            s_cnt <= 0;
        end else if (ser_en) begin
            s_sh  <= s_sh >> 1;
            s_cnt <= s_cnt + 1;
        end
    end

    assign ser_out  = s_sh[0];
    // Random junk on ser_done whenever the controller is not in DATA.
    assign ser_done = ser_en ? (s_cnt == W - 1) : noise;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s got=%0h exp=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a frame is a list of line bits with the cycle its start bit shows.
    typedef struct {
        logic [15:0] bits;
        int          len;
        int          start;
    } frame_t;

    frame_t exp_q[$];

    function automatic frame_t build_frame(input logic [W-1:0] d, input logic pe,
                                           input logic pt, input int start);
        frame_t f;
        int     n;
        f.bits = '0;
        n = 0;
        f.bits[n] = 1'b0;
        n++;
        for (int i = 0; i < W; i++) begin
            f.bits[n] = d[i];
            n++;
        end
        if (pe) begin
            f.bits[n] = (^d) ^ pt;
            n++;
        end
        for (int i = 0; i < STOP_BITS; i++) begin
            f.bits[n] = 1'b1;
            n++;
        end
        f.len   = n;
        f.start = start;
        return f;
    endfunction

    int cyc = 0;
    int free_at = 0;
    int b_lo = 1, b_hi = 0;
    int d_lo = 1, d_hi = 0;
    int acc_cnt = 0;
    int last_acc = 0;
    int flen;

    // Accept at edge k: Busy over edges k..k+L-1, DATA over k+1..k+W,
    // line frame over k+1..k+L, next accept allowed from edge k+L+1.
    initial begin
        forever begin
            @(posedge CLK);
            cyc++;
            if (!RST) begin
                exp_q.delete();
                free_at = 0;
                b_lo = 1; b_hi = 0;
                d_lo = 1; d_hi = 0;
            end else if (Data_Valid && cyc >= free_at) begin
                flen = 1 + W + int'(PAR_EN) + STOP_BITS;
                exp_q.push_back(build_frame(P_DATA, PAR_EN, PAR_TYP, cyc + 1));
                b_lo     = cyc;
                b_hi     = cyc + flen - 1;
                d_lo     = cyc + 1;
                d_hi     = cyc + W;
                free_at  = cyc + flen + 1;
                last_acc = cyc;
                acc_cnt++;
            end
        end
    end

    // Monitor: per-cycle Busy/ser_en, and whole-frame capture on TX_OUT.
    bit          coll = 1'b0;
    frame_t      cur;
    logic [15:0] got;
    int          idx;

    initial begin
        forever begin
            @(negedge CLK);
            if (!RST) begin
                coll = 1'b0;
            end else begin
                check("busy", Busy, (cyc >= b_lo) && (cyc <= b_hi));
                check("ser_en", ser_en, (cyc >= d_lo) && (cyc <= d_hi));
                if (coll) begin
                    got[idx] = TX_OUT;
                    idx++;
                    if (idx == cur.len) begin
                        check("frame", got, cur.bits);
                        coll = 1'b0;
                    end
                end else if (TX_OUT !== 1'b1) begin
                    check("start_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        cur = exp_q.pop_front();
                        check("start_cycle", cyc, cur.start);
                        got    = '0;
                        got[0] = TX_OUT;
                        idx    = 1;
                        coll   = 1'b1;
                    end
                end else if (exp_q.size() != 0) begin
                    check("start_on_time", cyc < exp_q[0].start, 1);
                end
            end
            noise = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [W-1:0] d, input logic pe, input logic pt, input bit hold);
        int c0;
        c0 = acc_cnt;
        @(negedge CLK);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Data_Valid = 1'b1;
        for (int i = 0; i < 100 && acc_cnt == c0; i++) @(negedge CLK);
        check("accept", acc_cnt != c0, 1);
        if (!hold) begin
            Data_Valid = 1'b0;
            P_DATA     = ~d;
            PAR_EN     = ~pe;
            PAR_TYP    = ~pt;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && (cyc < free_at || exp_q.size() != 0 || coll); i++)
            @(negedge CLK);
        check("idle_reached", (cyc >= free_at) && (exp_q.size() == 0) && !coll, 1);
    endtask

    initial begin
        #2 RST = 1'b0;
        #1;
        check("rst_tx", TX_OUT, 1);
        check("rst_busy", Busy, 0);
        check("rst_ser_en", ser_en, 0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (5) @(negedge CLK);

        send(8'hA5, 1'b1, 1'b0, 1'b0);
        wait_idle();
        send(8'hA5, 1'b1, 1'b1, 1'b0);
        wait_idle();
        send(8'h00, 1'b0, 1'b0, 1'b0);
        wait_idle();

        send(8'h3C, 1'b1, 1'b0, 1'b1);
        @(negedge CLK);
        P_DATA = 8'hFF;
        repeat (3) @(negedge CLK);
        send(8'hC3, 1'b0, 1'b1, 1'b0);
        wait_idle();

        for (int i = 0; i < 1500; i++) begin
            @(negedge CLK);
            Data_Valid = ($urandom_range(0, 3) == 0);
            P_DATA     = W'($urandom);
            PAR_EN     = 1'($urandom_range(0, 1));
            PAR_TYP    = 1'($urandom_range(0, 1));
        end
        Data_Valid = 1'b0;
        wait_idle();

        send(8'h5A, 1'b1, 1'b0, 1'b0);
        while (cyc < last_acc + 4) @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        check("abort_tx", TX_OUT, 1);
        check("abort_busy", Busy, 0);
        check("abort_ser_en", ser_en, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        send(8'h81, 1'b1, 1'b1, 1'b0);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Frame controller for the UART transmit path. It sits beside the serializer stage: it drives the serializer's enable, consumes its serial bit and done flag, and sees the same Data_Valid/Busy handshake.
- Builds the line frame: start bit, DATA_WIDTH data bits LSB-first, optional parity bit, stop bit.
- Drives the registered line output TX_OUT and the Busy flag that gates new-word acceptance in both blocks.

Parameters:
DATA_WIDTH, 8, data word width; must match the serializer's IN_WIDTH.

Ports:
CLK  input  1  clock; all state updates on rising edge.
RST  input  1  asynchronous active-low reset.
P_DATA  input  DATA_WIDTH  parallel word, used for parity; valid with Data_Valid.
Data_Valid  input  1  word-offer strobe; a word is accepted when Data_Valid=1 and Busy=0.
PAR_EN  input  1  1 = append a parity bit; sampled at accept.
PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled at accept.
ser_done  input  1  from serializer; high during the last data-bit cycle.
ser_out  input  1  from serializer; current data bit.
ser_en  output  1  to serializer Enable; shift/count enable.
Busy  output  1  frame in progress; also feeds the serializer Busy input.
TX_OUT  output  1  serial line; idle high.

Behaviour:
- Reset values (async, RST=0): state=IDLE, TX_OUT=1, Busy=0, ser_en=0, parity register=0. Reset mid-frame aborts immediately, with no partial stop bit.
- States: IDLE, START, DATA, PARITY, STOP.
- Accept: in IDLE with Data_Valid=1, go to START on that edge.
  - Same edge: capture parity bit = ^P_DATA XOR PAR_TYP.
  - Same edge: capture PAR_EN into par_en_r.
  - The serializer loads P_DATA on the same edge, through the same condition.
- Data_Valid while Busy=1 is ignored. The word is neither captured nor queued.
- START: exactly 1 cycle, then DATA.
- DATA:
  - ser_en=1, combinational from state; ser_en=0 in all other states.
  - Stay until ser_done=1, then go to PARITY if par_en_r=1, else STOP.
  - With an 8-bit word this is exactly 8 cycles; ser_out carries bit k in the k-th DATA cycle.
- PARITY: 1 cycle, then STOP.
- STOP: 1 cycle, then IDLE.
- Busy:
  - Registered; Busy(next) = (next_state != IDLE).
  - So Busy=1 from the cycle after accept through the STOP cycle, and Busy=0 in every IDLE cycle.
- Line mux, evaluated on the current state: IDLE→1, START→0, DATA→ser_out, PARITY→parity register, STOP→1.
- TX_OUT is the mux output registered once: a uniform 1-cycle lag versus state, and glitch-free.
- Frame length on TX_OUT:
  - 1 + DATA_WIDTH + par_en_r + 1 cycles.
  - Accept edge to first start-bit cycle on TX_OUT: 2 edges.
- Back-to-back: the earliest next accept is the first IDLE cycle after STOP. Between frames TX_OUT shows exactly 1 extra idle-high cycle after the stop bit.
- ser_done outside DATA is ignored.
- PAR_EN/PAR_TYP/P_DATA changing mid-frame have no effect on the current frame.

Optional Feature:
UART_TX_TWO_STOP_EN
- Defined: adds state STOP2 after STOP (TX_OUT=1, Busy held 1), giving 2 stop bits. Frame length +1.
- Undefined: STOP goes directly to IDLE; 1 stop bit. No STOP2 state exists in the netlist.

Test Plan:
- Reset, then idle 5 cycles → TX_OUT=1, Busy=0, ser_en=0 throughout.
- P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, with serializer attached → TX_OUT sequence 0,1,0,1,0,0,1,0,1,0(parity),1. Busy high for 11 cycles. ser_en high for exactly 8 cycles.
- P_DATA=0xA5, PAR_EN=1, PAR_TYP=1 → same frame with parity bit = 1. P_DATA=0x00, PAR_EN=0 → 0, eight 0s, 1 (10 bits), no PARITY state entered.
- Data_Valid held high; 0x3C then 0xC3 offered back-to-back → two complete frames with exactly 1 idle-high cycle between stop and start. A pulse of 0xFF during the first frame (Busy=1) is dropped.
- RST asserted during the 4th DATA cycle of 0x5A → TX_OUT=1, Busy=0, ser_en=0 asynchronously. After release, the next word 0x81 is transmitted correctly.
- With UART_TX_TWO_STOP_EN: 0xA5, PAR_EN=0 → 11-bit frame ending in 1,1; Busy high 11 cycles.
